// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: operand feeder for an N x N systolic array.
// Reads K operand vectors (A column k, B row k) from a buffer with one-cycle
// read latency and presents them skewed by one cycle per lane as
// {last, enable, data}. The run completes once the far-corner PE drains.
// Optional feature: define FEED_CTRL_PERF_CNT_EN to add perf_cycles_o, a
// saturating count of the cycles spent on the most recent operation.
module systolic_feed_ctrl #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KW         = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [KW-1:0]                 k_len_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          rd_en_o,
    output logic [KW-1:0]                 rd_addr_o,
    input  logic [N*DATA_WIDTH-1:0]       a_rd_data_i,
    input  logic [N*DATA_WIDTH-1:0]       b_rd_data_i,
    output logic [N*(DATA_WIDTH+2)-1:0]   a_feed_o,
    output logic [N*(DATA_WIDTH+2)-1:0]   b_feed_o,
    input  logic                          drain_vld_i
`ifdef FEED_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_cycles_o
`endif
);

    localparam int LW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          last_rd;

    // Control registers: state, latched K and read index.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control outputs; all outputs decode the current state only.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        last_rd   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    k_d     = k_len_i;
                    cnt_d   = '0;
                    state_d = (k_len_i != '0) ? FEED : DONE;
                end
            end
            FEED: begin
                rd_en_o   = 1'b1;
                rd_addr_o = cnt_q;
                // The counter stops at K-1, so K = 2^KW-1 never wraps it.
                if (cnt_q == k_q - KW'(1)) begin
                    last_rd = 1'b1;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + KW'(1);
                end
            end
            FLUSH: begin
                if (drain_vld_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Enable/last sideband chain: stage j lines up with lane j's element, so
    // lane i sees its read strobe delayed by i+1 registers.
    logic [N-1:0] vld_q, last_q;

    // Shift the read strobe and last-read marker one lane per cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= {vld_q[N-2:0], rd_en_o};
            last_q <= {last_q[N-2:0], last_rd};
        end
    end

    // Per-lane data path. The buffer's own output register supplies the first
    // delay stage; lane i adds i more so element k appears at s+2+k+i.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_dat, b_dat;

        if (i == 0) begin : g_direct
            assign a_dat = a_rd_data_i[DATA_WIDTH-1:0];
            assign b_dat = b_rd_data_i[DATA_WIDTH-1:0];
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] a_q [i];
            logic [DATA_WIDTH-1:0] b_q [i];

            // Skew delay line for lane i; cleared on reset like all skew state.
            // NOTE: these are discrete flops, not a RAM, so resetting them is
            // cheap and keeps the array inputs clean after a mid-run reset.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int m = 0; m < i; m++) begin
                        a_q[m] <= '0;
                        b_q[m] <= '0;
                    end
                end else begin
                    a_q[0] <= a_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    b_q[0] <= b_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    for (int m = 1; m < i; m++) begin
                        a_q[m] <= a_q[m-1];
                        b_q[m] <= b_q[m-1];
                    end
                end
            end

            assign a_dat = a_q[i-1];
            assign b_dat = b_q[i-1];
        end

        // Data is forced to zero whenever the lane carries no element.
        assign a_feed_o[i*LW +: LW] = {last_q[i], vld_q[i], vld_q[i] ? a_dat : '0};
        assign b_feed_o[i*LW +: LW] = {last_q[i], vld_q[i], vld_q[i] ? b_dat : '0};
    end

`ifdef FEED_CTRL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Cycle counter: the accept cycle counts as the first cycle of the
    // operation, each busy cycle adds one, saturating; IDLE holds the value.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (start_i) begin
                perf_d = 32'd1;
            end
        end else if (perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl (N=4, DATA_WIDTH=8, KW=8).
// Cycle 0 is the cycle in which start_i is high; the DUT accepts it at the
// edge ending cycle 0. Inputs change and outputs are sampled at the falling edge.
module tb_systolic_feed_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;
    localparam int LW = DW + 2;
    localparam int FW = N * LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy, done, rd_en;
    logic [KW-1:0] rd_addr;
    logic [N*DW-1:0] a_buf = '1;
    logic [N*DW-1:0] b_buf = '1;
    logic [FW-1:0] a_feed, b_feed;
    logic          drain;

    int total = 0;
    int bad   = 0;

    systolic_feed_ctrl #(.N(N), .DATA_WIDTH(DW), .KW(KW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .k_len_i     (k_len),
        .busy_o      (busy),
        .done_o      (done),
        .rd_en_o     (rd_en),
        .rd_addr_o   (rd_addr),
        .a_rd_data_i (a_buf),
        .b_rd_data_i (b_buf),
        .a_feed_o    (a_feed),
        .b_feed_o    (b_feed),
        .drain_vld_i (drain)
    );

    always #5 clk = ~clk;

    // Operand contents per (k, lane); distinct per lane and per step.
    function automatic logic [DW-1:0] fa(int k, int i);
        return DW'((i + 1) * 16 + k + 1);
    endfunction

    function automatic logic [DW-1:0] fb(int k, int i);
        return DW'(8'h80 + i * 8 + k * 3);
    endfunction

    // Buffer model with one-cycle read latency; holds its last word otherwise.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int i = 0; i < N; i++) begin
                a_buf[i*DW +: DW] <= fa(int'(rd_addr), i);
                b_buf[i*DW +: DW] <= fb(int'(rd_addr), i);
            end
        end
    end

    // Expected skewed feed vector in cycle c of a run of length k.
    function automatic logic [FW-1:0] exp_feed(int c, int k, bit is_b);
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            int e;
            e = c - 2 - i;
            if (e >= 0 && e < k) begin
                v[i*LW +: LW] = {(e == k - 1), 1'b1, is_b ? fb(e, i) : fa(e, i)};
            end
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One operation from start to the first IDLE cycle after DONE. drain_c is
    // the cycle drain_vld_i is high; disturb adds stray start/drain pulses.
    task automatic run(input int k, input int drain_c, input bit disturb);
        int done_c;
        done_c = (k == 0) ? 1 : drain_c + 1;
        start = 1'b1;
        k_len = KW'(k);
        drain = 1'b0;
        for (int c = 1; c <= done_c + 1; c++) begin
            bit rd_exp;
            @(negedge clk);
            start = 1'b0;
            drain = 1'b0;
            rd_exp = (c >= 1 && c <= k);
            check($sformatf("k%0d c%0d rd_en", k, c), 64'(rd_en), 64'(rd_exp));
            check($sformatf("k%0d c%0d rd_addr", k, c), 64'(rd_addr), rd_exp ? 64'(c - 1) : 64'd0);
            check($sformatf("k%0d c%0d busy", k, c), 64'(busy), 64'(c <= done_c));
            check($sformatf("k%0d c%0d done", k, c), 64'(done), 64'(c == done_c));
            check($sformatf("k%0d c%0d a_feed", k, c), 64'(a_feed), 64'(exp_feed(c, k, 1'b0)));
            check($sformatf("k%0d c%0d b_feed", k, c), 64'(b_feed), 64'(exp_feed(c, k, 1'b1)));
            if (c == drain_c || (disturb && c == 2)) drain = 1'b1;
            if (disturb && (c == 2 || c == 6)) begin
                start = 1'b1;
                k_len = KW'(7);
            end
        end
        start = 1'b0;
        drain = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " rd_en"}, 64'(rd_en), 64'd0);
        check({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, " a_feed"}, 64'(a_feed), 64'd0);
        check({tag, " b_feed"}, 64'(b_feed), 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        k_len = '0;
        drain = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        // Drain high while idle must not matter.
        drain = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        drain = 1'b0;

        // Basic K=3 run, started on the first edge after reset release.
        run(3, 12, 1'b0);
        // Back-to-back: start in the cycle right after DONE, with stray pulses.
        run(3, 12, 1'b1);
        // Zero-length operation goes straight to DONE.
        run(0, 0, 1'b0);
        // Shortest real run and early drain.
        run(1, 3, 1'b0);
        // Largest K: the read index must reach 254 without wrapping.
        run(255, 260, 1'b0);

        // Reset in the middle of FEED while rd_addr_o is 2.
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst addr before", 64'(rd_addr), 64'd2);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        run(2, 8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N rows x N columns of PEs), range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: operand width per lane.
REQ-003 Parameter KW, default 8: width of the K-length, read-address and counter fields.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 start_i  in  1  start request; sampled only in IDLE.
REQ-007 k_len_i  in  KW  number of MAC steps K; latched on an accepted start.
REQ-008 busy_o  out  1  high in every state except IDLE.
REQ-009 done_o  out  1  one-cycle completion pulse.
REQ-010 rd_en_o  out  1  operand buffer read strobe; buffer returns data exactly 1 cycle later.
REQ-011 rd_addr_o  out  KW  operand buffer read address (k index).
REQ-012 a_rd_data_i  in  N*DATA_WIDTH  A column vector k; lane i = row i.
REQ-013 b_rd_data_i  in  N*DATA_WIDTH  B row vector k; lane j = column j.
REQ-014 a_feed_o  out  N*(DATA_WIDTH+2)  per-row array input {last, enable, data}.
REQ-015 b_feed_o  out  N*(DATA_WIDTH+2)  per-column array input {last, enable, data}.
REQ-016 drain_vld_i  in  1  drain enable of PE(N-1,N-1).

Function
REQ-017 The FSM SHALL have states IDLE, FEED, FLUSH and DONE.
REQ-018 IDLE->FEED on start_i=1 with k_len_i!=0; IDLE->DONE on start_i=1 with k_len_i=0; start_i outside IDLE SHALL be ignored.
REQ-019 In FEED, rd_en_o SHALL be high for exactly K consecutive cycles, starting the cycle after start is accepted, with rd_addr_o = 0,1,...,K-1.
REQ-020 FEED->FLUSH SHALL occur in the cycle after the read with rd_addr_o=K-1 is issued.
REQ-021 Skew: lane i (A and B alike) SHALL present element k at cycle s+2+k+i, where s is the start-accept cycle; lane i SHALL use a register delay chain of depth i+1.
REQ-022 enable SHALL be 1 only on cycles carrying a valid element; data SHALL be 0 whenever enable=0.
REQ-023 last SHALL be 1 only together with element K-1 on each lane.
REQ-024 FLUSH->DONE SHALL occur in the cycle after drain_vld_i=1 is sampled.
REQ-025 drain_vld_i SHALL be ignored in IDLE and FEED.
REQ-026 DONE SHALL last one cycle, assert done_o, and return to IDLE; a new start_i SHALL be accepted from the following cycle.
REQ-027 The k counter SHALL be KW bits wide; K=2^KW-1 is the maximum and SHALL not wrap.

Reset
REQ-028 Asserting rst_i at any time, including mid-FEED/FLUSH, SHALL immediately force IDLE, clear all skew registers and counters, and drive busy_o=0, done_o=0, rd_en_o=0, rd_addr_o=0, a_feed_o=0 and b_feed_o=0.
REQ-029 The first start_i SHALL be accepted on the first rising edge after rst_i deasserts.

Configuration
REQ-030 With macro FEED_CTRL_PERF_CNT_EN defined, the block SHALL add port perf_cycles_o (out, 32 bits), cleared on accepted start, incremented every busy cycle, saturating at 2^32-1, and holding its value in IDLE; reset value SHALL be 0.
REQ-031 Without FEED_CTRL_PERF_CNT_EN defined, perf_cycles_o and its counter SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-032 N=4, K=3, start at cycle 0 -> rd_en_o high cycles 1-3 with addr 0,1,2; lane 0 enable at cycles 2-4 with last at 4; lane 3 enable at cycles 5-7 with last at 7.
REQ-033 K=3 run, drain_vld_i=1 at cycle 12 -> done_o=1 at cycle 13 and busy_o=0 at cycle 14.
REQ-034 start_i with k_len_i=0 -> busy_o=1 for one cycle, done_o pulses, rd_en_o and all enable bits stay 0.
REQ-035 start_i pulsed during FEED and FLUSH, drain_vld_i pulsed during FEED -> no effect on address sequence or done timing.
REQ-036 rst_i asserted mid-FEED (K=5, at addr 2) -> all outputs 0 asynchronously; a new K=2 start produces a clean sequence with addr 0,1.
REQ-037 FEED_CTRL_PERF_CNT_EN defined, K=3 run with drain at cycle 12 -> perf_cycles_o=14 after done; value holds in IDLE.
